// File: rtl/des_round_sequencer.sv
// Iterative DES round sequencer: holds L/R and C/D, one round per cycle; f-function and PC-2 are external.
// Optional abort input is compiled in when DES_ABORT_EN is defined.
module des_round_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_decrypt,
  input  logic [63:0] in_block,
  input  logic [55:0] in_cd,
  output logic [31:0] f_r,
  output logic [55:0] f_cd,
  input  logic [31:0] f_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block,
  output logic [3:0]  round
`ifdef DES_ABORT_EN
  ,
  input  logic        abort
`endif
);

  localparam int unsigned HALF_W = 32;
  localparam int unsigned KEY_W  = 28;
  localparam int unsigned RND_W  = 4;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  state_e             state_q, state_d;
  logic [HALF_W-1:0]  l_q, l_d, r_q, r_d;
  logic [KEY_W-1:0]   c_q, c_d, d_q, d_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic               dec_q, dec_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               single_shift;
  logic               abort_hit;

  // Rotate a 28-bit key half by one or two places in either direction.
  function automatic logic [KEY_W-1:0] rot(input logic [KEY_W-1:0] x, input logic right,
                                           input logic one);
    if (right) return one ? {x[0], x[KEY_W-1:1]} : {x[1:0], x[KEY_W-1:2]};
    return one ? {x[KEY_W-2:0], x[KEY_W-1]} : {x[KEY_W-3:0], x[KEY_W-1:KEY_W-2]};
  endfunction

  // Single-place shift before rounds 1, 8, 15; the extra one after round 15 restores the loaded C/D.
  assign single_shift = (round_q == RND_W'(0)) || (round_q == RND_W'(7)) ||
                        (round_q == RND_W'(14)) || (round_q == RND_W'(15));

`ifdef DES_ABORT_EN
  assign abort_hit = abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    round_d     = round_q;
    dec_d       = dec_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = ROUND;
          l_d        = in_block[63:32];
          r_d        = in_block[31:0];
          dec_d      = in_decrypt;
          round_d    = '0;
          c_d        = in_decrypt ? in_cd[55:28] : rot(in_cd[55:28], 1'b0, 1'b1);
          d_d        = in_decrypt ? in_cd[27:0]  : rot(in_cd[27:0],  1'b0, 1'b1);
          in_ready_d = 1'b0;
        end
      end
      ROUND: begin
        l_d     = r_q;
        r_d     = l_q ^ f_result;
        round_d = round_q + RND_W'(1);
        c_d     = rot(c_q, dec_q, single_shift);
        d_d     = rot(d_q, dec_q, single_shift);
        if (round_q == RND_W'(15)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_hit) begin
      state_d     = IDLE;
      l_d         = '0;
      r_d         = '0;
      c_d         = '0;
      d_d         = '0;
      round_d     = '0;
      dec_d       = 1'b0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      round_q     <= '0;
      dec_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      round_q     <= round_d;
      dec_q       <= dec_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_block = {r_q, l_q};
  assign round     = round_q;
  assign f_r       = r_q;
  assign f_cd      = {c_q, d_q};

endmodule

// File: tb/tb_des_round_sequencer.sv
// Bench for des_round_sequencer: supplies IP/FP/PC-1/PC-2/f models and checks against a software DES.
module tb_des_round_sequencer;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29,
                              28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int S_T [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_decrypt = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] in_block = '0;
  logic [55:0] in_cd = '0;
  logic        in_ready, out_valid;
  logic [31:0] f_r, f_result;
  logic [55:0] f_cd;
  logic [63:0] out_block;
  logic [3:0]  round;
`ifdef DES_ABORT_EN
  logic        abort = 1'b0;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  des_round_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
    .in_block(in_block), .in_cd(in_cd), .f_r(f_r), .f_cd(f_cd), .f_result(f_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .round(round)
`ifdef DES_ABORT_EN
    , .abort(abort)
`endif
  );

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = k[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s, p;
    logic [5:0]  b;
    int          row, col;
    for (int i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(32 - E_T[i])];
    e = e ^ k;
    for (int j = 0; j < 8; j++) begin
      b   = e[6'(47 - 6 * j) -: 6];
      row = int'({b[5], b[0]});
      col = int'(b[4:1]);
      s[5'(31 - 4 * j) -: 4] = 4'(S_T[9'(j * 64 + row * 16 + col)]);
    end
    for (int i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - P_T[i])];
    return p;
  endfunction

  function automatic logic [27:0] rol28(input logic [27:0] x, input int n);
    return (n == 1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  // Textbook DES: precompute 16 subkeys, run Feistel rounds, subkeys reversed for decrypt.
  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] data,
                                          input logic dec);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [63:0] lr;
    logic [31:0] l, r, t;
    cd = pc1(key);
    c  = cd[55:28];
    d  = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      c = rol28(c, (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2);
      d = rol28(d, (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2);
      ks[i] = pc2({c, d});
    end
    lr = ip(data);
    l  = lr[63:32];
    r  = lr[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_fn(r, dec ? ks[4'(15 - i)] : ks[4'(i)]);
      l = t;
    end
    return fp({r, l});
  endfunction

  // External PC-2 + f-function stand-in, combinational from the sequencer's outputs.
  always_comb f_result = f_fn(f_r, pc2(f_cd));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one block and return one step after the accepting edge, then scramble inputs.
  task automatic send(input logic [63:0] key, input logic [63:0] data, input logic dec);
    int n;
    n = 0;
    in_block   = ip(data);
    in_cd      = pc1(key);
    in_decrypt = dec;
    in_valid   = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL send_timeout: in_ready stayed %b, wanted 1", in_ready);
    end
    step();
    in_valid   = 1'b0;
    in_block   = {$urandom, $urandom};
    in_cd      = 56'({$urandom, $urandom});
    in_decrypt = 1'($urandom);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    cmp_cnt++;
    if ({in_ready, out_valid, round} !== {1'b1, 1'b0, 4'd0}) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got rdy/vld/rnd %b/%b/%0d want 1/0/0", in_ready, out_valid, round);
    end
    cmp_cnt++;
    if ({out_block, f_cd} !== 120'd0) begin
      err_cnt++;
      $display("FAIL reset_regs: got block %h cd %h want zeros", out_block, f_cd);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_kat_encrypt();
    out_ready = 1'b1;
    send(KEY, PT, 1'b0);
    for (int k = 0; k < 16; k++) begin
      cmp_cnt++;
      if ({in_ready, out_valid, round} !== {1'b0, 1'b0, 4'(k)}) begin
        err_cnt++;
        $display("FAIL enc_round%0d: got rdy/vld/rnd %b/%b/%0d want 0/0/%0d",
                 k, in_ready, out_valid, round, k);
      end
      step();
    end
    cmp_cnt++;
    if ({in_ready, out_valid, round} !== {1'b0, 1'b1, 4'd0}) begin
      err_cnt++;
      $display("FAIL enc_done: got rdy/vld/rnd %b/%b/%0d want 0/1/0", in_ready, out_valid, round);
    end
    cmp_cnt++;
    if (fp(out_block) !== CT) begin
      err_cnt++;
      $display("FAIL enc_kat: got %h want %h", fp(out_block), CT);
    end
    step();
    cmp_cnt++;
    if ({in_ready, out_valid} !== 2'b10) begin
      err_cnt++;
      $display("FAIL enc_release: got rdy/vld %b/%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_kat_decrypt();
    int n;
    out_ready = 1'b1;
    send(KEY, CT, 1'b1);
    wait_out(n);
    cmp_cnt++;
    if (n !== 16) begin
      err_cnt++;
      $display("FAIL dec_latency: got %0d want 16", n);
    end
    cmp_cnt++;
    if (fp(out_block) !== PT) begin
      err_cnt++;
      $display("FAIL dec_kat: got %h want %h", fp(out_block), PT);
    end
    cmp_cnt++;
    if (f_cd !== pc1(KEY)) begin
      err_cnt++;
      $display("FAIL dec_final_cd: got %h want %h", f_cd, pc1(KEY));
    end
    step();
  endtask

  task automatic test_backpressure();
    int n;
    logic [63:0] hold;
    out_ready = 1'b0;
    send(KEY, PT, 1'b0);
    wait_out(n);
    hold = out_block;
    cmp_cnt++;
    if (n !== 16 || fp(hold) !== CT) begin
      err_cnt++;
      $display("FAIL bp_result: got lat %0d ct %h want 16 %h", n, fp(hold), CT);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      cmp_cnt++;
      if ({out_valid, in_ready, out_block} !== {1'b1, 1'b0, hold}) begin
        err_cnt++;
        $display("FAIL bp_hold%0d: got vld/rdy/blk %b/%b/%h want 1/0/%h",
                 i, out_valid, in_ready, out_block, hold);
      end
    end
    out_ready = 1'b1;
    step();
    cmp_cnt++;
    if ({in_ready, out_valid} !== 2'b10) begin
      err_cnt++;
      $display("FAIL bp_release: got rdy/vld %b/%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_midway();
    int n;
    logic seen;
    out_ready = 1'b1;
    send(KEY, PT, 1'b0);
    n = 0;
    while (round != 4'd7 && n < 40) begin
      step();
      n++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmp_cnt++;
    if ({in_ready, out_valid, round, out_block, f_cd} !== {1'b1, 1'b0, 4'd0, 120'd0}) begin
      err_cnt++;
      $display("FAIL midrst_state: got rdy/vld/rnd %b/%b/%0d blk %h cd %h want 1/0/0 zeros",
               in_ready, out_valid, round, out_block, f_cd);
    end
    seen = 1'b0;
    repeat (20) begin
      step();
      seen = seen | out_valid;
    end
    cmp_cnt++;
    if (seen !== 1'b0) begin
      err_cnt++;
      $display("FAIL midrst_no_output: got out_valid pulse %b want 0", seen);
    end
    send(KEY, PT, 1'b0);
    wait_out(n);
    cmp_cnt++;
    if (n !== 16 || fp(out_block) !== CT) begin
      err_cnt++;
      $display("FAIL midrst_recover: got lat %0d ct %h want 16 %h", n, fp(out_block), CT);
    end
    step();
  endtask

  task automatic test_hold_inputs();
    logic [63:0] key, data;
    logic        dec;
    int          n;
    out_ready = 1'b1;
    key  = {$urandom, $urandom};
    data = {$urandom, $urandom};
    dec  = 1'($urandom);
    send(key, data, dec);
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      in_block   = {$urandom, $urandom};
      in_cd      = 56'({$urandom, $urandom});
      in_decrypt = 1'($urandom);
      step();
      n++;
    end
    in_valid = 1'b0;
    cmp_cnt++;
    if (n !== 16 || fp(out_block) !== des_ref(key, data, dec)) begin
      err_cnt++;
      $display("FAIL hold_inputs: got lat %0d res %h want 16 %h",
               n, fp(out_block), des_ref(key, data, dec));
    end
    step();
  endtask

  task automatic test_random_stream();
    localparam int N = 6;
    logic [63:0] exp_q [$];
    int          acc_q [$];
    logic [63:0] key, data, want;
    logic        dec, prev_ready;
    int          sent, got;
    sent = 0;
    got  = 0;
    out_ready = 1'b1;
    key  = {$urandom, $urandom};
    data = {$urandom, $urandom};
    dec  = 1'($urandom);
    in_block = ip(data); in_cd = pc1(key); in_decrypt = dec; in_valid = 1'b1;
    for (int cyc = 0; cyc < 18 * N + 60 && got < N; cyc++) begin
      prev_ready = in_ready;
      step();
      if (prev_ready && in_valid) begin
        exp_q.push_back(des_ref(key, data, dec));
        acc_q.push_back(cyc);
        sent++;
        if (sent == N) in_valid = 1'b0;
        else begin
          key  = {$urandom, $urandom};
          data = {$urandom, $urandom};
          dec  = 1'($urandom);
          in_block = ip(data); in_cd = pc1(key); in_decrypt = dec;
        end
      end
      if (out_valid) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        cmp_cnt++;
        if (fp(out_block) !== want) begin
          err_cnt++;
          $display("FAIL stream_result%0d: got %h want %h", got, fp(out_block), want);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    cmp_cnt++;
    if (got !== N) begin
      err_cnt++;
      $display("FAIL stream_count: got %0d results want %0d", got, N);
    end
    for (int i = 1; i < acc_q.size(); i++) begin
      cmp_cnt++;
      if (acc_q[i] - acc_q[i-1] !== 18) begin
        err_cnt++;
        $display("FAIL stream_period%0d: got %0d cycles want 18", i, acc_q[i] - acc_q[i-1]);
      end
    end
    step();
  endtask

`ifdef DES_ABORT_EN
  task automatic test_abort();
    int n;
    logic seen;
    out_ready = 1'b1;
    send(KEY, PT, 1'b0);
    n = 0;
    while (round != 4'd3 && n < 40) begin
      step();
      n++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    cmp_cnt++;
    if ({in_ready, out_valid, round, out_block, f_cd} !== {1'b1, 1'b0, 4'd0, 120'd0}) begin
      err_cnt++;
      $display("FAIL abort_state: got rdy/vld/rnd %b/%b/%0d blk %h want 1/0/0 zeros",
               in_ready, out_valid, round, out_block);
    end
    seen = 1'b0;
    repeat (20) begin
      step();
      seen = seen | out_valid;
    end
    cmp_cnt++;
    if (seen !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_no_output: got out_valid pulse %b want 0", seen);
    end
    send(KEY, PT, 1'b0);
    wait_out(n);
    cmp_cnt++;
    if (n !== 16 || fp(out_block) !== CT) begin
      err_cnt++;
      $display("FAIL abort_recover: got lat %0d ct %h want 16 %h", n, fp(out_block), CT);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_kat_encrypt();
    test_kat_decrypt();
    test_backpressure();
    test_reset_midway();
    test_hold_inputs();
    test_random_stream();
`ifdef DES_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", cmp_cnt);
    $fatal(1);
  end

endmodule

// File: doc/des_round_sequencer.md
DES_ROUND_SEQUENCER -- requirements
Module: des_round_sequencer

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high; ports clk and rst.
REQ-002 Port list SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request holds a block
- in_ready  out  1  sequencer can accept
- in_decrypt  in  1  1 = decrypt, 0 = encrypt
- in_block  in  64  post-IP block, [63:32] = L0, [31:0] = R0
- in_cd  in  56  post-PC-1 key, [55:28] = C0, [27:0] = D0
- f_r  out  32  R half driven to external f-function (expansion, XOR, S-box, P)
- f_cd  out  56  current C/D driven to external PC-2
- f_result  in  32  f-function result, combinational from f_r/f_cd
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- out_block  out  64  pre-FP result {R16, L16}
- round  out  4  current round index 0..15
- abort  in  1  present only with DES_ABORT_EN

Function
REQ-003 FSM SHALL have states IDLE, ROUND, DONE.
REQ-004 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid && in_ready at a rising edge.
REQ-005 On transfer, the block SHALL load L <= in_block[63:32], R <= in_block[31:0], latch in_decrypt, set round <= 0 and enter ROUND.
REQ-006 On transfer, C/D SHALL be loaded pre-rotated for round 0: encrypt rotates each half left by 1; decrypt loads unrotated.
REQ-007 In ROUND, f_r SHALL equal R and f_cd SHALL equal {C,D}, both direct from registers.
REQ-008 Each ROUND cycle SHALL update L <= R, R <= L ^ f_result, round <= round+1.
REQ-009 Each ROUND cycle SHALL rotate C and D independently for the next round n = round+1: encrypt rotates left 1 for n in {1,8,15}, else left 2; decrypt rotates right 1 for n in {1,8,15}, else right 2.
REQ-010 After the ROUND cycle with round = 15 the FSM SHALL enter DONE; the C/D rotation on that cycle is don't-care.
REQ-011 In DONE, out_valid SHALL be 1 and out_block SHALL be {R, L}, i.e. the final swap.
REQ-012 out_block, out_valid and all registers SHALL hold while out_valid && !out_ready.
REQ-013 On out_valid && out_ready the FSM SHALL return to IDLE; in_ready rises the next cycle. No same-cycle re-accept.
REQ-014 Latency SHALL be 16 cycles: out_valid is 1 in the 17th cycle after the accepting edge.
REQ-015 in_block, in_cd and in_decrypt SHALL be ignored outside IDLE.
REQ-016 round SHALL read 0 in IDLE and DONE.
REQ-017 Throughput SHALL be one block per 18 cycles with out_ready held high.

Reset
REQ-018 While rst = 1 at an edge, state SHALL become IDLE; in_ready = 1, out_valid = 0, round = 0, L/R/C/D = 0, out_block = 0.
REQ-019 Reset in ROUND or DONE SHALL discard the block with no out_valid pulse; the first post-reset accept SHALL behave normally.

Configuration
REQ-020 Macro DES_ABORT_EN defined: the abort input SHALL exist; abort = 1 in ROUND or DONE SHALL force IDLE next cycle with register values as in REQ-018, and out_valid SHALL drop. Abort SHALL be ignored in IDLE and SHALL override out_ready in DONE.
REQ-021 Macro DES_ABORT_EN undefined: no abort port SHALL exist and behaviour SHALL be as REQ-003..019.

Verification
(Bench wraps the DUT with reference IP, FP, PC-1, PC-2 and f-function models.)
REQ-022 Encrypt, key 133457799BBCDFF1, plaintext 0123456789ABCDEF, out_ready = 1 -> after FP, ciphertext 85E813540F0AB405 with out_valid exactly 16 cycles after accept.
REQ-023 Decrypt, key 133457799BBCDFF1, ciphertext 85E813540F0AB405 -> plaintext 0123456789ABCDEF; final C/D equals the loaded value.
REQ-024 Encrypt with out_ready = 0 for 5 cycles after out_valid -> out_block stable and in_ready = 0 throughout; IDLE one cycle after out_ready = 1.
REQ-025 rst pulsed at round = 7 -> next cycle in_ready = 1, out_valid = 0, all registers 0; a following encrypt of REQ-022 produces the correct result.
REQ-026 in_valid held high with changing in_block during ROUND -> result matches only the block captured at accept.
REQ-027 With DES_ABORT_EN, abort at round = 3 -> IDLE next cycle and no out_valid; REQ-022 passes immediately afterwards.
